// File: rtl/conv_lane_reduce.sv
// Lane reduction and channel accumulation for the conv dot product: sums N_REG lanes of
// N_CH vectors on top of a bias, then saturates. Optional macro CONV_REDUCE_RELU_EN clamps negatives.
module conv_lane_reduce #(
  parameter int WIDTH = 32,
  parameter int FBITS = 24,
  parameter int N_REG = 31,
  parameter int N_CH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_REG*WIDTH-1:0] all_mult,
  input  logic [WIDTH-1:0]       bias,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_ovf
);

  localparam int ACC_W  = WIDTH + $clog2(N_REG*N_CH+1);
  localparam int LANE_W = (N_REG > 1) ? $clog2(N_REG) : 1;
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_REG-1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(N_CH-1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SUM  = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  // Products are already in the output Q format, so FBITS only constrains legal configurations.
  if (N_CH < 1 || FBITS >= WIDTH) begin : g_param_check
    $error("conv_lane_reduce: N_CH must be >= 1 and FBITS < WIDTH");
  end

  logic [1:0]              state;
  logic [LANE_W-1:0]       lane_cnt;
  logic [CH_W-1:0]         ch_cnt;
  logic signed [ACC_W-1:0] acc;
  logic [N_REG*WIDTH-1:0]  vec;
  logic                    accept;
  logic [ACC_W-WIDTH:0]    acc_top;
  logic                    sat_ovf;
  logic [WIDTH-1:0]        sat_data;

  assign in_ready = (state == S_IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // NOTE: the vector register is pure datapath, always loaded before use, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept)
      vec <= all_mult;
    else if (state == S_SUM)
      vec <= vec >> WIDTH;
  end

  // The result fits WIDTH exactly when every bit above the output sign bit matches it.
  assign acc_top = acc[ACC_W-1:WIDTH-1];

  always_comb begin
    sat_ovf  = !((&acc_top) || !(|acc_top));
    sat_data = acc[WIDTH-1:0];
    if (sat_ovf)
      sat_data = acc[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`ifdef CONV_REDUCE_RELU_EN
    if (sat_data[WIDTH-1])
      sat_data = '0;
`else
`endif
  end

  // NOTE: all state below is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      lane_cnt  <= '0;
      ch_cnt    <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lane_cnt <= '0;
            state    <= S_SUM;
            if (ch_cnt == '0)
              acc <= {{(ACC_W-WIDTH){bias[WIDTH-1]}}, bias};
          end
        end
        S_SUM: begin
          acc <= acc + {{(ACC_W-WIDTH){vec[WIDTH-1]}}, vec[WIDTH-1:0]};
          if (lane_cnt == LAST_LANE) begin
            lane_cnt <= '0;
            if (ch_cnt == LAST_CH) begin
              state <= S_EMIT;
            end else begin
              ch_cnt <= ch_cnt + 1'b1;
              state  <= S_IDLE;
            end
          end else begin
            lane_cnt <= lane_cnt + 1'b1;
          end
        end
        S_EMIT: begin
          // First EMIT cycle registers the saturated result; the handshake then retires the group.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= sat_data;
            out_ovf   <= sat_ovf;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            ch_cnt    <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_lane_reduce.md
# conv_lane_reduce

Sequential reduction stage that consumes the packed per-tap product vectors from the element-wise multiplier and completes the convolution dot product. It sums the `N_REG` Q-format lanes of each vector, accumulates the sums over `N_CH` input-channel vectors on top of a bias, saturates the total to `WIDTH`, and presents one output sample through a valid/ready handshake. It sits between the element-wise multiplier and the activation/writeback stage of each conv layer.

## Interface
- `WIDTH`, 32: word width of lanes, bias and output (two's complement Q format).
- `FBITS`, 24: fractional bits. Products arrive already rescaled to Q(WIDTH-FBITS).FBITS, so no shifts are applied here.
- `N_REG`, 31: lanes per vector (kernel taps).
- `N_CH`, 16: vectors accumulated per output sample (input channels); must be ≥ 1.
- localparam `ACC_W` = WIDTH + $clog2(N_REG*N_CH+1): internal accumulator width.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  product vector valid.
- `in_ready`  out  1  block accepts a vector.
- `all_mult`  in  N_REG*WIDTH  packed products; lane g = bits [(g+1)*WIDTH-1 : g*WIDTH].
- `bias`  in  WIDTH  sampled only when the first vector of a group is accepted.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  WIDTH  saturated result.
- `out_ovf`  out  1  saturation occurred for this result; valid with `out_valid`.

## Operation
- FSM states: IDLE, SUM, EMIT. Counters: `lane_cnt` 0..N_REG-1, `ch_cnt` 0..N_CH-1.
- IDLE: `in_ready`=1. On `in_valid && in_ready`: latch `all_mult` into the vector register, set `lane_cnt`=0, go to SUM. If `ch_cnt`==0, load the accumulator with sign-extended `bias`; otherwise keep it.
- SUM: each cycle, add sign-extended lane `lane_cnt` to the accumulator and increment `lane_cnt`. Lanes are added in order 0..N_REG-1. After lane N_REG-1:
  - If `ch_cnt`==N_CH-1, go to EMIT.
  - Otherwise increment `ch_cnt` and go to IDLE.
- EMIT: `out_valid`=1 and `in_ready`=0. `out_data` is the accumulator saturated to WIDTH: values > 2^(WIDTH-1)-1 become 0x7FFF_FFFF, values < -2^(WIDTH-1) become 0x8000_0000. `out_ovf`=1 iff clamping occurred. On `out_ready`: clear the accumulator, set `ch_cnt`=0, go to IDLE.
- ACC_W guarantees that no internal overflow is possible. Saturation is applied only at EMIT.
- `out_data` and `out_ovf` are registered. They are held stable while `out_valid && !out_ready`.
- `in_ready` is low throughout SUM and EMIT. There is no input/output overlap.
- Input changes on `all_mult` after acceptance have no effect. `bias` is ignored while `ch_cnt`≠0.

## Timing
- Reset (async assert, sync release): state=IDLE, counters=0, accumulator=0, `out_valid`=0, `out_data`=0, `out_ovf`=0, `in_ready`=0 while `rst` is high and 1 in the first cycle after release.
- A vector accepted at edge T has its lanes added on edges T+1..T+N_REG.
- For a non-final vector: `in_ready`=1 again in the cycle after edge T+N_REG, giving a throughput of one vector per N_REG+1 cycles.
- For the final vector: `out_valid` rises after edge T+N_REG+1 (32 cycles at defaults). After the `out_ready` handshake edge, `in_ready`=1 in the next cycle.
- Reset mid-group or mid-EMIT discards the partial sum and any pending result. The next accepted vector starts a fresh group with bias reload.

## Configuration
- `CONV_REDUCE_RELU_EN`
  - Defined: after saturation, a negative result is replaced with 0x0000_0000. `out_ovf` still reflects saturation of the pre-ReLU value.
  - Undefined: the signed saturated value is output unchanged.

## Test plan
- All 31 lanes = 0x0100_0000 (1.0), bias 0, 16 vectors → total 496.0 → `out_data`=0x7FFF_FFFF, `out_ovf`=1.
- Lane 0 = 0x0080_0000 (0.5), other lanes 0, bias=0x0100_0000, 16 vectors (bias changed on vectors 2..16) → `out_data`=0x0900_0000, `out_ovf`=0.
- All lanes = 0xFF00_0000 (-1.0), bias 0, 16 vectors → 0x8000_0000 with `out_ovf`=1. With `CONV_REDUCE_RELU_EN` → 0x0000_0000 with `out_ovf`=1.
- Hold `out_ready`=0 for 10 cycles in EMIT → `out_data` stable, `in_ready`=0 throughout. Raise `out_ready` → one handshake, then `in_ready`=1 next cycle.
- Assert `rst` after 5 accepted vectors, then feed test 2 → result 0x0900_0000 (no residue from the aborted group).
- Hold `in_valid`=1 → `in_ready` pulses every 32 cycles. `out_valid` asserts 32 cycles after the 16th acceptance.
